// File: rtl/echo_line_acq.sv
// echo_line_acq: per-trigger receive-line acquisition sequencer.
// After a trigger it discards cfg_dly samples, then emits cfg_len outputs,
// each made from a group of 2^k samples (group mean or first sample) and
// tagged with the channel. At the end of each line it moves the receive-mux
// select (fixed channel or next channel in the scan mask) and waits SETTLE
// cycles for the mux to settle before accepting another trigger.
// Handshake: din is consumed only in cycles where din_en=1. dout is valid
// only in the single cycle where dout_en=1. There is no back-pressure.
module echo_line_acq #(
  parameter int DATA_W = 14,
  parameter int CH_NUM = 8,
  parameter int SEL_W  = 3,
  parameter int DLY_W  = 16,
  parameter int LEN_W  = 12,
  parameter int K_MAX  = 4,
  parameter int SETTLE = 16,
  localparam int K_W   = $clog2(K_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_en,
  input  logic              cfg_scan,
  input  logic [SEL_W-1:0]  cfg_ch,
  input  logic [CH_NUM-1:0] cfg_mask,
  input  logic [DLY_W-1:0]  cfg_dly,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [K_W-1:0]    cfg_k,
  input  logic              cfg_avg,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  output logic [SEL_W-1:0]  dout_ch,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              trig_miss,
  output logic [1:0]        state_dbg
);

  localparam int ACC_W = DATA_W + K_MAX;
  localparam int GRP_W = K_MAX;
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_CAPTURE, ST_SETTLE} state_t;

  state_t              state, state_nxt;
  logic                trig_q;
  logic                trig_edge;
  logic [DLY_W-1:0]    dly_r, dly_cnt;
  logic [LEN_W-1:0]    len_r, out_cnt;
  logic [K_W-1:0]      k_r, k_sat;
  logic                avg_r, scan_r;
  logic [GRP_W-1:0]    grp_cnt, grp_max;
  logic [ACC_W-1:0]    sum_r, sum_add;
  logic [DATA_W-1:0]   first_r, first_cur, avg_val;
  logic [SET_W-1:0]    settle_cnt;
  logic [SEL_W-1:0]    next_sel;
  logic                line_scan;
  logic                start, cap_out, line_end, grp_last;

  assign trig_edge = trig & ~trig_q;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign k_sat     = (cfg_k > K_W'(K_MAX)) ? K_W'(K_MAX) : cfg_k;
  assign grp_max   = GRP_W'((1 << k_r) - 1);
  assign grp_last  = (grp_cnt == grp_max);
  // A new group restarts the sum and the first-sample holder.
  assign sum_add   = (grp_cnt == '0) ? ACC_W'(din) : sum_r + ACC_W'(din);
  assign first_cur = (grp_cnt == '0) ? din : first_r;
  assign avg_val   = DATA_W'(sum_add >> k_r);
  // An empty line ends in the trigger cycle, before scan mode is latched.
  assign line_scan = (state == ST_IDLE) ? cfg_scan : scan_r;

  // Next enabled channel strictly above sel, wrapping; unchanged if mask is 0.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    next_sel = sel;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = SEL_W'((int'(sel) + i) % CH_NUM);
      if (!found && cfg_mask[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    cap_out   = 1'b0;
    line_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_edge) begin
          start = 1'b1;
          if (cfg_len == '0) begin
            line_end  = 1'b1;
            state_nxt = ST_SETTLE;
          end else if (cfg_dly == '0) begin
            state_nxt = ST_CAPTURE;
          end else begin
            state_nxt = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (din_en && dly_cnt == dly_r - DLY_W'(1)) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (din_en && grp_last) begin
          cap_out = 1'b1;
          if (out_cnt + LEN_W'(1) == len_r) begin
            line_end  = 1'b1;
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: config latch, counters, accumulator, outputs and channel select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q     <= 1'b1;
      dly_r      <= '0;
      len_r      <= '0;
      k_r        <= '0;
      avg_r      <= 1'b0;
      scan_r     <= 1'b0;
      dly_cnt    <= '0;
      out_cnt    <= '0;
      grp_cnt    <= '0;
      sum_r      <= '0;
      first_r    <= '0;
      settle_cnt <= '0;
      sel        <= '0;
      dout       <= '0;
      dout_en    <= 1'b0;
      dout_ch    <= '0;
      dout_last  <= 1'b0;
      done       <= 1'b0;
      trig_miss  <= 1'b0;
    end else begin
      trig_q    <= trig;
      dout_en   <= 1'b0;
      dout_last <= 1'b0;
      done      <= 1'b0;
      trig_miss <= trig_edge && (state != ST_IDLE);
      if (start) begin
        dly_r      <= cfg_dly;
        len_r      <= cfg_len;
        k_r        <= k_sat;
        avg_r      <= cfg_avg;
        scan_r     <= cfg_scan;
        dly_cnt    <= '0;
        out_cnt    <= '0;
        grp_cnt    <= '0;
        sum_r      <= '0;
        first_r    <= '0;
        settle_cnt <= '0;
      end
      if (state == ST_DELAY && din_en) dly_cnt <= dly_cnt + DLY_W'(1);
      if (state == ST_CAPTURE && din_en) begin
        sum_r   <= sum_add;
        first_r <= first_cur;
        grp_cnt <= grp_last ? '0 : grp_cnt + GRP_W'(1);
      end
      if (cap_out) begin
        dout    <= avg_r ? avg_val : first_cur;
        dout_en <= 1'b1;
        dout_ch <= sel;
        out_cnt <= out_cnt + LEN_W'(1);
      end
      if (state == ST_SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
      if (line_end) begin
        dout_last  <= cap_out;
        done       <= 1'b1;
        settle_cnt <= '0;
        sel        <= line_scan ? next_sel : cfg_ch;
      end else if (state == ST_IDLE && !cfg_scan) begin
        sel <= cfg_ch;
      end
    end
  end

endmodule

// File: tb/tb_echo_line_acq.sv
// Directed bench for echo_line_acq with hand-computed expected values.
module tb_echo_line_acq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [13:0] din;
  logic        din_en;
  logic        cfg_scan;
  logic [2:0]  cfg_ch;
  logic [7:0]  cfg_mask;
  logic [15:0] cfg_dly;
  logic [11:0] cfg_len;
  logic [2:0]  cfg_k;
  logic        cfg_avg;
  logic [2:0]  sel;
  logic [13:0] dout;
  logic        dout_en;
  logic [2:0]  dout_ch;
  logic        dout_last;
  logic        busy;
  logic        done;
  logic        trig_miss;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int grp_vec [8] = '{10, 12, 14, 16, 1, 1, 1, 5};
  int scan_ch [5] = '{0, 2, 7, 0, 2};

  echo_line_acq dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .din(din), .din_en(din_en),
    .cfg_scan(cfg_scan), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask),
    .cfg_dly(cfg_dly), .cfg_len(cfg_len), .cfg_k(cfg_k), .cfg_avg(cfg_avg),
    .sel(sel), .dout(dout), .dout_en(dout_en), .dout_ch(dout_ch),
    .dout_last(dout_last), .busy(busy), .done(done), .trig_miss(trig_miss),
    .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Run-time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic feed(input logic [13:0] v);
    din    = v;
    din_en = 1'b1;
    tick();
  endtask

  task automatic settle_out();
    din_en = 1'b0;
    repeat (16) tick();
    chk("busy_after_settle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b1; din = '0; din_en = 1'b0;
    cfg_scan = 1'b0; cfg_ch = 3'd5; cfg_mask = 8'h00; cfg_dly = 16'd3;
    cfg_len = 12'd4; cfg_k = 3'd0; cfg_avg = 1'b0;

    // Reset state, trig held high through reset.
    repeat (3) tick();
    chk("rst_sel", sel, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_en", dout_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_miss", trig_miss, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_edge_after_rst", busy, 0);
    chk("sel_tracks_ch", sel, 5);
    trig = 1'b0;
    tick();

    // Fixed ch 5, dly 3, len 4, k 0: dout 3..6.
    pulse_trig();
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 7; i++) begin
      feed(14'(i));
      chk("t1_en", dout_en, (i >= 3));
      if (i >= 3) begin
        chk("t1_dout", dout, i);
        chk("t1_ch", dout_ch, 5);
        chk("t1_last", dout_last, (i == 6));
        chk("t1_done", done, (i == 6));
      end
    end
    din_en = 1'b0;
    repeat (15) tick();
    chk("t1_busy_d15", busy, 1);
    tick();
    chk("t1_busy_d16", busy, 0);

    // Averaging k=2, len 2, dly 0: 13 then 2.
    cfg_avg = 1'b1; cfg_k = 3'd2; cfg_len = 12'd2; cfg_dly = 16'd0;
    pulse_trig();
    for (int i = 0; i < 8; i++) begin
      feed(14'(grp_vec[i]));
      chk("t2_en", dout_en, (i == 3 || i == 7));
      if (i == 3) chk("t2_dout0", dout, 13);
      if (i == 7) begin
        chk("t2_dout1", dout, 2);
        chk("t2_last", dout_last, 1);
        chk("t2_done", done, 1);
      end
    end
    settle_out();

    // Decimation k=2: 10 then 1.
    cfg_avg = 1'b0;
    pulse_trig();
    for (int i = 0; i < 8; i++) begin
      feed(14'(grp_vec[i]));
      chk("t3_en", dout_en, (i == 3 || i == 7));
      if (i == 3) chk("t3_dout0", dout, 10);
      if (i == 7) chk("t3_dout1", dout, 1);
    end
    settle_out();

    // Scan mask 1000_0101 from ch 0: lines on 0, 2, 7, 0.
    cfg_ch = 3'd0;
    tick();
    chk("t4_sel0", sel, 0);
    cfg_scan = 1'b1; cfg_mask = 8'h85; cfg_len = 12'd1; cfg_k = 3'd0;
    for (int n = 0; n < 4; n++) begin
      chk("t4_sel_idle", sel, scan_ch[n]);
      pulse_trig();
      chk("t4_sel_hold", sel, scan_ch[n]);
      feed(14'(100 + n));
      chk("t4_dout", dout, 100 + n);
      chk("t4_ch", dout_ch, scan_ch[n]);
      chk("t4_done", done, 1);
      chk("t4_sel_next", sel, scan_ch[n + 1]);
      settle_out();
      chk("t4_sel_settled", sel, scan_ch[n + 1]);
    end

    // Trigger during CAPTURE: trig_miss, line unchanged.
    cfg_scan = 1'b0; cfg_ch = 3'd3; cfg_len = 12'd3;
    tick();
    pulse_trig();
    feed(14'd20);
    chk("t5_dout0", dout, 20);
    chk("t5_miss0", trig_miss, 0);
    trig = 1'b1;
    feed(14'd21);
    chk("t5_miss1", trig_miss, 1);
    chk("t5_dout1", dout, 21);
    trig = 1'b0;
    feed(14'd22);
    chk("t5_dout2", dout, 22);
    chk("t5_last", dout_last, 1);
    chk("t5_done", done, 1);
    chk("t5_miss2", trig_miss, 0);
    chk("t5_ch", dout_ch, 3);
    settle_out();

    // Reset mid-CAPTURE, then a clean line on cfg_ch.
    cfg_ch = 3'd6; cfg_len = 12'd4;
    tick();
    pulse_trig();
    feed(14'd30);
    chk("t6_dout0", dout, 30);
    feed(14'd31);
    din_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_en", dout_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_ch", dout_ch, 0);
    repeat (2) tick();
    chk("t6_rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_sel_ch", sel, 6);
    chk("t6_idle", busy, 0);
    cfg_len = 12'd2;
    pulse_trig();
    feed(14'd40);
    chk("t6_new0", dout, 40);
    chk("t6_new_ch", dout_ch, 6);
    feed(14'd41);
    chk("t6_new1", dout, 41);
    chk("t6_new_last", dout_last, 1);
    settle_out();

    // len=0: done without dout_en or dout_last.
    cfg_len = 12'd0;
    pulse_trig();
    chk("t7_done", done, 1);
    chk("t7_en", dout_en, 0);
    chk("t7_last", dout_last, 0);
    chk("t7_busy", busy, 1);
    tick();
    chk("t7_done_pulse", done, 0);
    repeat (14) tick();
    chk("t7_busy_d15", busy, 1);
    tick();
    chk("t7_busy_d16", busy, 0);

    // Full scale k=4 average: no overflow.
    cfg_len = 12'd1; cfg_k = 3'd4; cfg_avg = 1'b1;
    pulse_trig();
    for (int i = 0; i < 16; i++) begin
      feed(14'd16383);
      chk("t8_en", dout_en, (i == 15));
    end
    chk("t8_dout", dout, 16383);
    settle_out();

    // cfg_k above K_MAX saturates to 16-sample groups: mean of 0..15 is 7.
    cfg_k = 3'd7;
    pulse_trig();
    for (int i = 0; i < 16; i++) begin
      feed(14'(i));
      chk("t9_en", dout_en, (i == 15));
    end
    chk("t9_dout", dout, 7);
    settle_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_line_acq.md
# echo_line_acq

Parametrised acquisition sequencer for the ultrasound receive path, the multi-channel successor to the single-stream ADC capture. It sits between the ADC deserialiser's sample stream (dout/doutEn) and downstream buffering. On each sync trigger it drives the receive-mux select, waits a programmable delay, and captures a window of samples. Captured samples can be decimated or 2^k-averaged, and each output is tagged with its channel. In scan mode it steps through a channel mask, one line per trigger.

## Interface
Parameters:
- DATA_W, 14, ADC sample width (unsigned, offset binary)
- CH_NUM, 8, number of receive channels
- SEL_W, 3, width of channel select (2^SEL_W ≥ CH_NUM)
- DLY_W, 16, delay counter width (samples)
- LEN_W, 12, line length width (output samples)
- K_MAX, 4, maximum log2 averaging/decimation factor
- SETTLE, 16, mux settle cycles after a channel change (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- trig  in  1  sync trigger, synchronous level; rising edge starts a line
- din  in  DATA_W  ADC sample
- din_en  in  1  din valid strobe
- cfg_scan  in  1  0 = fixed channel cfg_ch; 1 = scan cfg_mask
- cfg_ch  in  SEL_W  fixed-mode channel
- cfg_mask  in  CH_NUM  scan-mode enabled channels
- cfg_dly  in  DLY_W  samples discarded after trigger
- cfg_len  in  LEN_W  output samples per line
- cfg_k  in  clog2(K_MAX+1)  group size 2^cfg_k; values above K_MAX saturate to K_MAX
- cfg_avg  in  1  1 = output group mean; 0 = output first sample of group
- sel  out  SEL_W  receive-mux channel select
- dout  out  DATA_W  output sample
- dout_en  out  1  dout valid, one cycle
- dout_ch  out  SEL_W  channel of dout
- dout_last  out  1  with dout_en on final sample of line
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at line end
- trig_miss  out  1  one-cycle pulse: trigger edge seen while not IDLE

## Operation
- States: IDLE, DELAY, CAPTURE, SETTLE.
- IDLE: on a trig rising edge, latch all cfg_* except cfg_ch/cfg_mask (already applied to sel). Clear counters. Go to DELAY, or to CAPTURE if cfg_dly=0.
- cfg_len=0: the line completes with no output. done pulses, no dout_last, proceed as end of line.
- DELAY: count din_en. After cfg_dly strobes, go to CAPTURE. The strobe after the cfg_dly-th is the first captured.
- CAPTURE: accumulate into a DATA_W+K_MAX bit sum, with a group counter 0..2^k−1.
  - On the group's last din_en: dout = avg ? sum>>k : first sample of group; dout_en=1; dout_ch=sel.
  - Increment the output count. At cfg_len: dout_last=1, done=1, go to SETTLE.
- End of line, channel update:
  - fixed mode: sel ← cfg_ch.
  - scan mode: sel ← next set bit of cfg_mask above current sel, wrapping modulo CH_NUM.
  - mask=0: sel unchanged.
  - Only the mask value present at end of line is used.
- SETTLE: count SETTLE clk cycles, then IDLE. sel is stable throughout.
- In IDLE with cfg_scan=0, sel tracks cfg_ch every cycle.
- Trigger edges outside IDLE: ignored, trig_miss pulses; the line in progress is unaffected.
- Edge detector: a registered copy of trig. After reset its previous value is 1, so a trig held high through reset produces no edge.
- Reset (async, any state): state IDLE; sel=0; dout=0; dout_en, dout_last, done, trig_miss, busy=0; all counters and the sum cleared. The line is abandoned with no done.

## Timing
- Trigger edge at cycle t (trig=1, prev=0): busy=1 from t+1.
- Output latency: dout_en is registered, asserted the cycle after the din_en completing a group. dout_last and done are coincident with it.
- busy stays high through SETTLE. It falls SETTLE cycles after done. IDLE resumes the next cycle, and a trigger edge that cycle is accepted.
- din_en may be asserted every cycle. The block never stalls, and it has no back-pressure.
- Samples with din_en=0 are ignored in all states.

## Test plan
- Fixed ch 5, dly=3, len=4, k=0, din_en every cycle, din = sample index 0,1,2,… -> dout 3,4,5,6 on consecutive cycles; dout_ch=5; dout_last on 6; done coincident; busy low 16 cycles later.
- avg=1, k=2, len=2, dly=0, din 10,12,14,16,1,1,1,5 -> dout 13 then 2.
- avg=0, k=2, same din -> dout 10 then 1.
- Scan mask=8'b1000_0101, sel starts at 0, four triggers -> lines on ch 0,2,7,0; sel changes only at each done.
- Trigger during CAPTURE -> trig_miss pulse; line completes unchanged. rst_n low mid-CAPTURE -> all outputs 0 immediately; no done; next trigger after release starts a clean line on ch 0 (or cfg_ch in fixed mode).
- len=0 -> done with no dout_en. Full-scale din=16383, k=4, avg=1 -> dout 16383 (no overflow).
